r22sdf_frame_ctrl: RTL and testbench

- Frame sequencer for the enable-gated R22SDF FFT pipeline.
- Accepts a valid/ready sample stream and drives the pipeline's shared sys_en.
- Waits for twiddle/CORDIC ready, inserts zero-padded dummy frames to flush the pipeline, and tags pipeline output with valid/sop/eop/index.
- Sits between the sample source, the FFT stage chain, and the result consumer.

---
 rtl/r22sdf_frame_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_r22sdf_frame_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/r22sdf_frame_ctrl.sv
// r22sdf_frame_ctrl
// Frame sequencer for the enable-gated R22SDF FFT pipeline. It admits a
// valid/ready sample stream, drives the shared pipeline advance enable,
// pads with zero-valued dummy blocks to push real frames out, and tags the
// pipeline output with valid/sop/eop/index.
//
// Ports
//   sys_clk   in   clock
//   sys_nrst  in   asynchronous active-low reset
//   fft_rdy   in   AND of all stage CORDIC ready flags
//   s_valid   in   upstream sample valid
//   s_ready   out  upstream sample accepted when s_valid & s_ready
//   fft_en    out  pipeline advance enable (drives sys_en)
//   din_sel   out  1 = pass upstream sample, 0 = force pipeline input to zero
//   m_valid   out  pipeline output holds a real-frame result
//   m_ready   in   downstream accepts result
//   m_sop     out  m_valid & output index 0
//   m_eop     out  m_valid & output index N-1
//   m_idx     out  output index within the frame (pipeline order)
//   busy      out  a real frame is inside the pipeline or partially input
module r22sdf_frame_ctrl #(
  parameter int LOG2N     = 14,
  parameter int PIPE_LAT  = 16400,
  parameter int TAG_DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_nrst,
  input  logic             fft_rdy,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             fft_en,
  output logic             din_sel,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_sop,
  output logic             m_eop,
  output logic [LOG2N-1:0] m_idx,
  output logic             busy
);

  localparam int FILL_W = $clog2(PIPE_LAT + 1);
  localparam int PTR_W  = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W  = $clog2(TAG_DEPTH + 1);

  localparam logic [LOG2N-1:0]  IDX_LAST  = {LOG2N{1'b1}};
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PIPE_LAT);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(TAG_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(TAG_DEPTH);

  typedef enum logic [1:0] {
    ST_WAIT_RDY = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RUN      = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  state_t              state_r, state_s, resume_r;
  logic [LOG2N-1:0]    in_idx_r, out_idx_r;
  logic [FILL_W-1:0]   fill_r;
  logic [TAG_DEPTH-1:0] tag_mem_r;
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    tag_cnt_r, real_cnt_r;
  logic                m_valid_r, m_sop_r, m_eop_r;
  logic [LOG2N-1:0]    m_idx_r;

  logic stall_s, en_s, s_ready_s, din_sel_s, busy_s;
  logic push_s, pop_s, out_fire_s, head_tag_s, full_s;

  assign stall_s    = m_valid_r & ~m_ready;
  assign busy_s     = (real_cnt_r != {CNT_W{1'b0}}) | (state_r == ST_RUN);
  // A new block begins whenever the pipeline advances with in_idx at zero.
  assign push_s     = en_s & (in_idx_r == {LOG2N{1'b0}});
  // Output samples only exist once the pipeline has been filled.
  assign out_fire_s = en_s & (fill_r == FILL_FULL);
  assign head_tag_s = (tag_cnt_r != {CNT_W{1'b0}}) & tag_mem_r[rd_ptr_r];
  assign pop_s      = out_fire_s & (out_idx_r == IDX_LAST) & (tag_cnt_r != {CNT_W{1'b0}});
  assign full_s     = (tag_cnt_r == CNT_FULL);

  // Next-state and stream/enable decode.
  always_comb begin
    state_s   = state_r;
    en_s      = 1'b0;
    s_ready_s = 1'b0;
    din_sel_s = 1'b0;
    case (state_r)
      ST_WAIT_RDY: begin
        if (fft_rdy) state_s = resume_r;
        else         state_s = ST_WAIT_RDY;
      end
      ST_IDLE: begin
        din_sel_s = 1'b1;
        s_ready_s = fft_rdy & ~stall_s;
        en_s      = s_valid & fft_rdy & ~stall_s;
        if (!fft_rdy)     state_s = ST_WAIT_RDY;
        else if (s_valid) state_s = stall_s ? ST_IDLE : ST_RUN;
        else if (busy_s)  state_s = ST_FLUSH;
        else              state_s = ST_IDLE;
      end
      ST_RUN: begin
        din_sel_s = 1'b1;
        s_ready_s = fft_rdy & ~stall_s;
        en_s      = s_valid & fft_rdy & ~stall_s;
        if (!fft_rdy)                          state_s = ST_WAIT_RDY;
        else if (en_s && in_idx_r == IDX_LAST) state_s = ST_IDLE;
        else                                   state_s = ST_RUN;
      end
      ST_FLUSH: begin
        en_s = fft_rdy & ~stall_s;
        if (!fft_rdy)                          state_s = ST_WAIT_RDY;
        else if (en_s && in_idx_r == IDX_LAST) state_s = ST_IDLE;
        else                                   state_s = ST_FLUSH;
      end
      default: state_s = ST_WAIT_RDY;
    endcase
  end

  // State register; remembers where to resume after a ready drop.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_r  <= ST_WAIT_RDY;
      resume_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
      if (state_r != ST_WAIT_RDY && state_s == ST_WAIT_RDY) resume_r <= state_r;
      else                                                   resume_r <= resume_r;
    end
  end

  // Input index, fill level and output index all advance only on enabled cycles.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      in_idx_r  <= {LOG2N{1'b0}};
      out_idx_r <= {LOG2N{1'b0}};
      fill_r    <= {FILL_W{1'b0}};
    end else begin
      if (en_s) in_idx_r <= in_idx_r + LOG2N'(1);
      if (en_s && fill_r != FILL_FULL) fill_r <= fill_r + FILL_W'(1);
      if (out_fire_s) out_idx_r <= out_idx_r + LOG2N'(1);
    end
  end

  // Frame-tag FIFO (1 = real block, 0 = dummy) plus a count of real tags.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      tag_mem_r  <= {TAG_DEPTH{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      tag_cnt_r  <= {CNT_W{1'b0}};
      real_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= din_sel_s;
        wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   tag_cnt_r <= tag_cnt_r + CNT_W'(1);
        2'b01:   tag_cnt_r <= tag_cnt_r - CNT_W'(1);
        default: tag_cnt_r <= tag_cnt_r;
      endcase
      real_cnt_r <= real_cnt_r + CNT_W'(push_s & din_sel_s) - CNT_W'(pop_s & head_tag_s);
    end
  end

  // Output tagging; the presented sample is frozen while downstream stalls.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      m_valid_r <= 1'b0;
      m_sop_r   <= 1'b0;
      m_eop_r   <= 1'b0;
      m_idx_r   <= {LOG2N{1'b0}};
    end else if (stall_s) begin
      m_valid_r <= m_valid_r;
    end else if (out_fire_s) begin
      m_valid_r <= head_tag_s;
      m_idx_r   <= out_idx_r;
      m_sop_r   <= head_tag_s & (out_idx_r == {LOG2N{1'b0}});
      m_eop_r   <= head_tag_s & (out_idx_r == IDX_LAST);
    end else begin
      m_valid_r <= 1'b0;
      m_sop_r   <= 1'b0;
      m_eop_r   <= 1'b0;
    end
  end

  assign fft_en  = en_s;
  assign s_ready = s_ready_s;
  assign din_sel = din_sel_s;
  assign busy    = busy_s;
  assign m_valid = m_valid_r;
  assign m_sop   = m_sop_r;
  assign m_eop   = m_eop_r;
  assign m_idx   = m_idx_r;

  r22sdf_frame_ctrl_chk u_chk (
    .clk   (sys_clk),
    .rst_n (sys_nrst),
    .push  (push_s),
    .pop   (pop_s),
    .full  (full_s)
  );

endmodule

// Checker: a push into a full tag FIFO means TAG_DEPTH is too small for PIPE_LAT.
module r22sdf_frame_ctrl_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input logic full
);
  a_no_tag_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: tb/tb_r22sdf_frame_ctrl.sv
// Testbench for r22sdf_frame_ctrl (N=16, PIPE_LAT=20, TAG_DEPTH=3).
// The reference model works on whole blocks of enabled cycles: every enabled
// cycle belongs to a block of N (real or dummy), and the output presented
// after enabled cycle c is input sample c-PIPE_LAT of that block sequence.
module tb_r22sdf_frame_ctrl;
  localparam int LOG2N = 4;
  localparam int N     = 16;
  localparam int PL    = 20;
  localparam int TD    = 3;

  logic             sys_clk = 1'b0;
  logic             sys_nrst, fft_rdy, s_valid, s_ready, fft_en, din_sel;
  logic             m_valid, m_ready, m_sop, m_eop, busy;
  logic [LOG2N-1:0] m_idx;

  r22sdf_frame_ctrl #(.LOG2N(LOG2N), .PIPE_LAT(PL), .TAG_DEPTH(TD)) dut (
    .sys_clk (sys_clk), .sys_nrst(sys_nrst), .fft_rdy(fft_rdy),
    .s_valid (s_valid), .s_ready (s_ready),  .fft_en (fft_en),
    .din_sel (din_sel), .m_valid (m_valid),  .m_ready(m_ready),
    .m_sop   (m_sop),   .m_eop   (m_eop),    .m_idx  (m_idx),
    .busy    (busy)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit md_wait, md_act, md_kind, e_mv;
  int md_pos, en_total, e_idx;
  bit kinds[$];
  int accepted, beats;

  task automatic model_reset();
    md_wait = 1'b1; md_act = 1'b0; md_kind = 1'b0; e_mv = 1'b0;
    md_pos = 0; en_total = 0; e_idx = 0;
    kinds.delete();
  endtask

  // Real blocks whose last output sample has not yet left the pipeline.
  function automatic int real_pending();
    int cnt = 0;
    foreach (kinds[b]) if (kinds[b] && ((b + 1) * N + PL > en_total)) cnt++;
    return cnt;
  endfunction

  // Compare registered outputs against the model, away from the active edge.
  task automatic sample();
    @(negedge sys_clk);
    check_val("m_valid", m_valid, e_mv);
    check_val("m_sop", m_sop, (e_mv && e_idx == 0));
    check_val("m_eop", m_eop, (e_mv && e_idx == N - 1));
    if (e_mv) check_val("m_idx", m_idx, e_idx);
    check_val("busy", busy, (real_pending() > 0));
  endtask

  // Drive inputs for the coming edge, check enable/ready, advance the model.
  task automatic apply(input bit sv, input bit mr, input bit fr);
    bit stall, bsy, x_en, x_srdy, x_dsel;
    int c, j;
    s_valid = sv; m_ready = mr; fft_rdy = fr;
    #1;
    stall  = e_mv && !mr;
    bsy    = (real_pending() > 0);
    x_en   = 1'b0;
    x_srdy = 1'b0;
    x_dsel = !md_wait && !(md_act && !md_kind);
    if (md_wait) begin
      if (fr) md_wait = 1'b0;
    end else if (!fr) begin
      md_wait = 1'b1;
    end else if (md_act) begin
      x_srdy = md_kind && !stall;
      x_en   = !stall && (md_kind ? sv : 1'b1);
    end else begin
      x_srdy = !stall;
      if (sv) begin
        if (!stall) begin x_en = 1'b1; md_act = 1'b1; md_kind = 1'b1; md_pos = 0; end
      end else if (bsy) begin
        md_act = 1'b1; md_kind = 1'b0; md_pos = 0;
      end
    end
    check_val("fft_en", fft_en, x_en);
    check_val("s_ready", s_ready, x_srdy);
    check_val("din_sel", din_sel, x_dsel);
    if (m_valid && mr) beats++;
    if (sv && x_srdy) accepted++;
    if (x_en) begin
      c = en_total + 1;
      if (md_pos == 0) kinds.push_back(md_kind);
      md_pos++;
      if (md_pos == N) begin md_act = 1'b0; md_pos = 0; end
      en_total = c;
      if (c > PL) begin
        j = c - PL - 1;
        e_mv  = kinds[j / N];
        e_idx = j % N;
      end else begin
        e_mv = 1'b0;
      end
    end else if (!stall) begin
      e_mv = 1'b0;
    end
  endtask

  // Feed samples until nframes complete frames are accepted, with optional
  // s_valid gap, downstream stall at an output index, fft_rdy drop, or random.
  task automatic drive(input int nframes, input int gap_at, input int gap_len,
                       input int stall_idx, input int drop_at, input int drop_len,
                       input bit rnd);
    int gap_left = gap_len;
    int st_left  = 4;
    int dr_left  = drop_len;
    int guard    = 0;
    bit sv, mr, fr;
    while (accepted < nframes * N && guard < 4000) begin
      guard++;
      sample();
      sv = 1'b1; mr = 1'b1; fr = 1'b1;
      if (rnd) begin
        sv = ($urandom_range(0, 99) < 75);
        mr = ($urandom_range(0, 99) < 80);
        fr = ($urandom_range(0, 99) >= 4);
      end
      if (gap_at >= 0 && accepted == gap_at && gap_left > 0) begin sv = 1'b0; gap_left--; end
      if (stall_idx >= 0 && m_valid && m_idx == stall_idx && st_left > 0) begin mr = 1'b0; st_left--; end
      if (drop_at >= 0 && accepted == drop_at && dr_left > 0) begin fr = 1'b0; dr_left--; end
      apply(sv, mr, fr);
    end
    if (guard >= 4000) check_val("drive_timeout", guard, 0);
  endtask

  // Run with no input until every real frame has left and flushing stopped.
  task automatic drain();
    int guard = 0;
    while ((md_act || md_wait || real_pending() > 0 || e_mv) && guard < 1000) begin
      guard++;
      sample();
      apply(1'b0, 1'b1, 1'b1);
    end
    if (guard >= 1000) check_val("drain_timeout", guard, 0);
    sample();
    apply(1'b0, 1'b1, 1'b1);
    check_val("idle_fft_en", fft_en, 0);
    check_val("idle_busy", busy, 0);
    check_val("beats", beats, (accepted / N) * N);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sys_nrst = 1'b0; fft_rdy = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge sys_clk);
    #1;
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_fft_en", fft_en, 0);
    check_val("rst_s_ready", s_ready, 0);
    check_val("rst_busy", busy, 0);
    sys_nrst = 1'b1;
    repeat (10) begin sample(); apply(1'b1, 1'b1, 1'b0); end

    // Single frame followed by flushing
    accepted = 0; beats = 0;
    drive(1, -1, 0, -1, -1, 0, 1'b0);
    drain();

    // Three back-to-back frames
    accepted = 0; beats = 0;
    drive(3, -1, 0, -1, -1, 0, 1'b0);
    drain();

    // s_valid gap of 5 cycles at in_idx 7
    accepted = 0; beats = 0;
    drive(1, 7, 5, -1, -1, 0, 1'b0);
    drain();

    // Downstream stall of 4 cycles at m_idx 3
    accepted = 0; beats = 0;
    drive(2, -1, 0, 3, -1, 0, 1'b0);
    drain();

    // fft_rdy drop of 6 cycles at in_idx 9
    accepted = 0; beats = 0;
    drive(1, -1, 0, -1, 9, 6, 1'b0);
    drain();

    // Randomized s_valid / m_ready / fft_rdy
    accepted = 0; beats = 0;
    drive(10, -1, 0, -1, -1, 0, 1'b1);
    drain();

    // Reset pulse mid-frame at in_idx 9
    accepted = 0;
    for (int g = 0; g < 200 && accepted < 9; g++) begin sample(); apply(1'b1, 1'b1, 1'b1); end
    @(negedge sys_clk);
    sys_nrst = 1'b0;
    #1;
    check_val("pulse_m_valid", m_valid, 0);
    check_val("pulse_fft_en", fft_en, 0);
    check_val("pulse_s_ready", s_ready, 0);
    check_val("pulse_busy", busy, 0);
    model_reset();
    repeat (2) @(negedge sys_clk);
    sys_nrst = 1'b1;
    accepted = 0; beats = 0;
    apply(1'b0, 1'b1, 1'b1);
    drive(1, -1, 0, -1, -1, 0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
